// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder; the single arithmetic cell time-shared by the serial adder.
module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_p;

  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & w_p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: loads a, b, cin, steps one full-adder cell LSB-first for WIDTH
// cycles, then holds sum/cout on an output handshake until the consumer takes them.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshakes: a transfer happens on the rising edge where valid & ready are both high.
  // in_ready is high only in IDLE, out_valid only in DONE; neither side's ready depends on
  // the other side's valid, so no combinational path crosses the block.

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_cout;
  logic               w_s;
  logic               w_c;
  logic               w_last;

  serial_fa_cell u_cell (
    .i_a  (r_a_sr[0]),
    .i_b  (r_b_sr[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_c)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // The sum register fills from the top so that after WIDTH shifts bit 0 lands at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) r_cout <= w_c;
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit instance for directed scenarios and a 2-bit
// instance swept over every operand combination with random output stalls.
module tb_serial_adder_ctrl;
  import adder_pkg::*;

  logic clk;
  logic rst;

  // 8-bit instance
  logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [7:0] a, b, sum;
  state_t     dbg8;

  // 2-bit instance
  logic       in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2, busy2;
  logic [1:0] a2, b2, sum2;
  state_t     dbg2;

  logic [8:0] exp_q[$];
  logic [2:0] exp2_q[$];
  int total;
  int bad;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .busy(busy), .dbg_state(dbg8)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2),
    .busy(busy2), .dbg_state(dbg2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: offer an op on the 8-bit DUT, return at the negedge after the acceptance edge
  task automatic accept8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; cin = tc;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL accept_wait: in_ready=%b required=1", in_ready);
    end
    @(posedge clk);
    exp_q.push_back({1'b0, ta} + {1'b0, tb} + {8'd0, tc});
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL accept_busy: busy=%b in_ready=%b required busy=1 in_ready=0", busy, in_ready);
    end
  endtask

  // scoreboard pop with out_ready=1; called at the negedge right after acceptance (k=0)
  task automatic collect8(input string name, input int exp_lat);
    int k;
    logic [8:0] e;
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL %s_timeout: out_valid=%b required=1", name, out_valid);
      return;
    end
    total++;
    if (k !== exp_lat) begin
      bad++; $display("FAIL %s_latency: got=%0d required=%0d", name, k, exp_lat);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1xx;
    total++;
    if ({cout, sum} !== e) begin
      bad++; $display("FAIL %s_result: cout,sum=%h required=%h", name, {cout, sum}, e);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, sum, cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      bad++; $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b required 1/0/0/00/0",
                      in_ready, out_valid, busy, sum, cout);
    end
    total++;
    if (dbg8 !== ST_IDLE || dbg2 !== ST_IDLE) begin
      bad++; $display("FAIL reset_state: dbg8=%0d dbg2=%0d required=0", dbg8, dbg2);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, in_ready2, out_valid2} !== 5'b10010) begin
      bad++; $display("FAIL idle_after_reset: got=%b required=10010",
                      {in_ready, out_valid, busy, in_ready2, out_valid2});
    end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    accept8(8'h5A, 8'h3C, 1'b0);
    collect8("basic", 8);
  endtask

  task automatic test_wrap;
    out_ready = 1'b1;
    accept8(8'hFF, 8'h01, 1'b0);
    collect8("wrap_ff_01", 8);
    accept8(8'hFF, 8'hFF, 1'b1);
    collect8("wrap_ff_ff_c", 8);
  endtask

  task automatic test_back_pressure;
    int n;
    logic [8:0] held;
    logic [8:0] e;
    out_ready = 1'b0;
    accept8(8'h22, 8'h33, 1'b0);
    in_valid = 1'b1; a = 8'h11; b = 8'h01; cin = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_run_ready: in_ready=%b required=0", in_ready);
      end
    end
    held = {cout, sum};
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1xx;
    total++;
    if (held !== e) begin
      bad++; $display("FAIL bp_result: cout,sum=%h required=%h", held, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({cout, sum} !== e || out_valid !== 1'b1 || in_ready !== 1'b0 || dbg8 !== ST_DONE) begin
        bad++; $display("FAIL bp_hold: cout,sum=%h out_valid=%b in_ready=%b state=%0d required %h/1/0/2",
                        {cout, sum}, out_valid, in_ready, dbg8, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    exp_q.push_back(9'h012);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_take_new: busy=%b in_ready=%b required 1/0", busy, in_ready);
    end
    collect8("bp_new_op", 8);
  endtask

  task automatic test_reset_mid_run;
    out_ready = 1'b1;
    accept8(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, busy, sum, in_ready} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      bad++; $display("FAIL midrst_outputs: out_valid=%b busy=%b sum=%h in_ready=%b required 0/0/00/1",
                      out_valid, busy, sum, in_ready);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL midrst_no_partial: out_valid=%b required=0", out_valid);
      end
    end
    accept8(8'h01, 8'h01, 1'b0);
    collect8("after_reset", 8);
  endtask

  task automatic test_exhaustive_w2;
    int n;
    logic done;
    logic [2:0] e;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      out_ready2 = 1'b0;
      in_valid2 = 1'b1; a2 = i[1:0]; b2 = i[3:2]; cin2 = i[4];
      n = 0;
      while (in_ready2 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      exp2_q.push_back({1'b0, i[1:0]} + {1'b0, i[3:2]} + {2'b00, i[4]});
      @(negedge clk);
      in_valid2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      done = 1'b0;
      n = 0;
      while (!done && n < 60) begin
        out_ready2 = (n > 20) ? 1'b1 : 1'($urandom_range(0, 1));
        if (out_valid2 === 1'b1 && out_ready2) begin
          e = (exp2_q.size() > 0) ? exp2_q.pop_front() : 3'bxxx;
          total++;
          if ({cout2, sum2} !== e) begin
            bad++; $display("FAIL w2_result[%0d]: cout,sum=%b required=%b", i, {cout2, sum2}, e);
          end
          done = 1'b1;
        end
        @(negedge clk);
        n++;
      end
      if (!done) begin
        total++; bad++;
        $display("FAIL w2_timeout[%0d]: out_valid=%b required=1", i, out_valid2);
      end
    end
    out_ready2 = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b0;
    test_reset;
    test_basic;
    test_wrap;
    test_back_pressure;
    test_reset_mid_run;
    test_exhaustive_w2;
    total++;
    if (exp_q.size() !== 0 || exp2_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_drain: left8=%0d left2=%0d required 0/0", exp_q.size(), exp2_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
